// File: rtl/led_pattern_sequencer_if.sv
// Host command channel for the LED pattern sequencer: mode/speed offered over valid/ready.
interface led_pattern_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_speed;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_speed,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_speed,
        output cmd_ready
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Step-rate prescaler and pattern state machine for a chain of NUM 8-LED boards.
// Commands switch mode/speed through a blank-then-seed SWITCH cycle; pause freezes stepping.
module led_pattern_sequencer #(
    parameter int unsigned NUM      = 4,
    parameter int unsigned BASE_DIV = 50000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    led_pattern_sequencer_if.slave  cmd,
    input  logic                    pause,
    output logic [NUM*8-1:0]        led_all,
    output logic                    step,
    output logic [1:0]              mode_o
);
    localparam int unsigned W = NUM * 8;

    localparam logic [1:0] MODE_ROL    = 2'd0;
    localparam logic [1:0] MODE_ROR    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       speed_q, speed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     led_q, led_d;
    logic             dir_q, dir_d;      // bounce direction: 0 = towards MSB, 1 = towards LSB
    logic             step_q, step_d;

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt_last;
    logic [W-1:0]     led_next;
    logic             accept;

    function automatic logic [W-1:0] seed_of(input logic [1:0] mode);
        case (mode)
            MODE_ROL:    seed_of = {NUM{8'h01}};
            MODE_ROR:    seed_of = {NUM{8'h80}};
            MODE_BOUNCE: seed_of = W'(1);
            default:     seed_of = '1;
        endcase
    endfunction

    function automatic logic [W-1:0] advance(input logic [1:0] mode,
                                             input logic [W-1:0] cur,
                                             input logic dir_down);
        case (mode)
            MODE_ROL:    advance = {cur[W-2:0], cur[W-1]};
            MODE_ROR:    advance = {cur[0], cur[W-1:1]};
            MODE_BOUNCE: advance = dir_down ? (cur >> 1) : (cur << 1);
            MODE_BLINK:  advance = ~cur;
            default:     advance = cur;
        endcase
    endfunction

    // Step period is evaluated at the counter width so large BASE_DIV values wrap consistently.
    assign period   = CNT_W'(BASE_DIV) * (CNT_W'(speed_q) + CNT_W'(1));
    assign cnt_last = period - CNT_W'(1);
    assign led_next = advance(mode_q, led_q, dir_q);

    assign cmd.cmd_ready = (state_q != ST_SWITCH);
    assign led_all       = led_q;
    assign step          = step_q;
    assign mode_o        = mode_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        accept  = cmd.cmd_valid && (state_q != ST_SWITCH);

        // An accepted command takes priority over any tick due in the same cycle.
        if (accept) begin
            mode_d  = cmd.cmd_mode;
            speed_d = cmd.cmd_speed;
            cnt_d   = '0;
            led_d   = '0;
            state_d = ST_SWITCH;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cnt_q == cnt_last) begin
                        cnt_d  = '0;
                        led_d  = led_next;
                        step_d = 1'b1;
                        if (mode_q == MODE_BOUNCE) begin
                            if (led_next[W-1]) begin
                                dir_d = 1'b1;
                            end else if (led_next[0]) begin
                                dir_d = 1'b0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (pause) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    led_d   = seed_of(mode_q);
                    dir_d   = 1'b0;
                    state_d = pause ? ST_HOLD : ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            mode_q  <= MODE_ROL;
            speed_q <= '0;
            cnt_q   <= '0;
            led_q   <= {NUM{8'h01}};
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with NUM=2 (W=16) and BASE_DIV=4.
module tb_led_pattern_sequencer;
    logic        clk;
    logic        rst_n;
    logic        pause;
    logic [15:0] led_all;
    logic        step;
    logic [1:0]  mode_o;
    int          checks;
    int          fails;

    led_pattern_sequencer_if cmd_if ();

    led_pattern_sequencer #(
        .NUM      (2),
        .BASE_DIV (4),
        .CNT_W    (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (cmd_if),
        .pause   (pause),
        .led_all (led_all),
        .step    (step),
        .mode_o  (mode_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] mode, input logic [3:0] speed);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_mode  = mode;
        cmd_if.cmd_speed = speed;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pause = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_mode  = 2'd0;
        cmd_if.cmd_speed = 4'd0;
        cyc();
        cyc();
        checks++; if (led_all !== 16'h0101) begin fails++; $display("FAIL reset_led: got %h want %h", led_all, 16'h0101); end
        checks++; if (mode_o !== 2'd0) begin fails++; $display("FAIL reset_mode: got %0d want 0", mode_o); end
        checks++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b want 0", step); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready); end
        rst_n = 1'b1;
        repeat (3) cyc();
        checks++; if (led_all !== 16'h0101 || step !== 1'b0) begin fails++; $display("FAIL rol_pre_tick: led %h step %b want 0101/0", led_all, step); end
        cyc();
        checks++; if (led_all !== 16'h0202 || step !== 1'b1) begin fails++; $display("FAIL rol_tick1: led %h step %b want 0202/1", led_all, step); end
        repeat (7) cyc();
        checks++; if (led_all !== 16'h0404 || step !== 1'b0) begin fails++; $display("FAIL rol_mid: led %h step %b want 0404/0", led_all, step); end
        cyc();
        checks++; if (led_all !== 16'h0808 || step !== 1'b1) begin fails++; $display("FAIL rol_tick3: led %h step %b want 0808/1", led_all, step); end
    endtask

    task automatic test_rotate_right();
        send_cmd(2'd1, 4'd0);
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin fails++; $display("FAIL ror_ready_before: got %b want 1", cmd_if.cmd_ready); end
        cyc();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (led_all !== 16'h0000 || step !== 1'b0) begin fails++; $display("FAIL ror_blank: led %h step %b want 0000/0", led_all, step); end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin fails++; $display("FAIL ror_ready_switch: got %b want 0", cmd_if.cmd_ready); end
        checks++; if (mode_o !== 2'd1) begin fails++; $display("FAIL ror_mode: got %0d want 1", mode_o); end
        cyc();
        checks++; if (led_all !== 16'h8080 || step !== 1'b0) begin fails++; $display("FAIL ror_seed: led %h step %b want 8080/0", led_all, step); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin fails++; $display("FAIL ror_ready_after: got %b want 1", cmd_if.cmd_ready); end
        repeat (3) cyc();
        checks++; if (led_all !== 16'h8080 || step !== 1'b0) begin fails++; $display("FAIL ror_pre_tick: led %h step %b want 8080/0", led_all, step); end
        cyc();
        checks++; if (led_all !== 16'h4040 || step !== 1'b1) begin fails++; $display("FAIL ror_tick1: led %h step %b want 4040/1", led_all, step); end
    endtask

    task automatic test_bounce();
        logic [15:0] exp;
        int sh;
        send_cmd(2'd2, 4'd0);
        cyc();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (led_all !== 16'h0000) begin fails++; $display("FAIL bnc_blank: led %h want 0000", led_all); end
        cyc();
        checks++; if (led_all !== 16'h0001 || mode_o !== 2'd2) begin fails++; $display("FAIL bnc_seed: led %h mode %0d want 0001/2", led_all, mode_o); end
        for (int t = 1; t <= 31; t++) begin
            repeat (3) cyc();
            cyc();
            sh  = (t <= 15) ? t : ((t <= 30) ? (30 - t) : 1);
            exp = 16'h0001 << sh;
            checks++; if (led_all !== exp || step !== 1'b1) begin fails++; $display("FAIL bnc_tick%0d: led %h step %b want %h/1", t, led_all, step, exp); end
        end
    endtask

    task automatic test_pause();
        repeat (2) cyc();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++; if (led_all !== 16'h0002 || step !== 1'b0) begin fails++; $display("FAIL pause_frozen%0d: led %h step %b want 0002/0", i, led_all, step); end
        end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin fails++; $display("FAIL pause_ready: got %b want 1", cmd_if.cmd_ready); end
        pause = 1'b0;
        cyc();
        checks++; if (led_all !== 16'h0002 || step !== 1'b0) begin fails++; $display("FAIL resume_first: led %h step %b want 0002/0", led_all, step); end
        cyc();
        checks++; if (led_all !== 16'h0004 || step !== 1'b1) begin fails++; $display("FAIL resume_tick: led %h step %b want 0004/1", led_all, step); end
    endtask

    task automatic test_blink();
        send_cmd(2'd3, 4'd3);
        cyc();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (led_all !== 16'h0000) begin fails++; $display("FAIL blink_blank: led %h want 0000", led_all); end
        cyc();
        checks++; if (led_all !== 16'hFFFF || mode_o !== 2'd3) begin fails++; $display("FAIL blink_seed: led %h mode %0d want FFFF/3", led_all, mode_o); end
        repeat (15) cyc();
        checks++; if (led_all !== 16'hFFFF || step !== 1'b0) begin fails++; $display("FAIL blink_pre_tick: led %h step %b want FFFF/0", led_all, step); end
        cyc();
        checks++; if (led_all !== 16'h0000 || step !== 1'b1) begin fails++; $display("FAIL blink_tick1: led %h step %b want 0000/1", led_all, step); end
        repeat (16) cyc();
        checks++; if (led_all !== 16'hFFFF || step !== 1'b1) begin fails++; $display("FAIL blink_tick2: led %h step %b want FFFF/1", led_all, step); end
    endtask

    task automatic test_collision();
        repeat (15) cyc();
        send_cmd(2'd0, 4'd0);
        cyc();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (step !== 1'b0 || led_all !== 16'h0000) begin fails++; $display("FAIL coll_step: led %h step %b want 0000/0", led_all, step); end
        checks++; if (mode_o !== 2'd0) begin fails++; $display("FAIL coll_mode: got %0d want 0", mode_o); end
        cyc();
        checks++; if (led_all !== 16'h0101 || step !== 1'b0) begin fails++; $display("FAIL coll_seed: led %h step %b want 0101/0", led_all, step); end
        repeat (4) cyc();
        checks++; if (led_all !== 16'h0202 || step !== 1'b1) begin fails++; $display("FAIL coll_speed0: led %h step %b want 0202/1", led_all, step); end
    endtask

    task automatic test_cmd_with_pause();
        pause = 1'b1;
        send_cmd(2'd1, 4'd0);
        cyc();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (led_all !== 16'h0000 || cmd_if.cmd_ready !== 1'b0) begin fails++; $display("FAIL cp_blank: led %h ready %b want 0000/0", led_all, cmd_if.cmd_ready); end
        cyc();
        checks++; if (led_all !== 16'h8080 || cmd_if.cmd_ready !== 1'b1) begin fails++; $display("FAIL cp_seed: led %h ready %b want 8080/1", led_all, cmd_if.cmd_ready); end
        repeat (6) cyc();
        checks++; if (led_all !== 16'h8080 || step !== 1'b0) begin fails++; $display("FAIL cp_hold: led %h step %b want 8080/0", led_all, step); end
        pause = 1'b0;
        repeat (4) cyc();
        checks++; if (led_all !== 16'h8080 || step !== 1'b0) begin fails++; $display("FAIL cp_resume_pre: led %h step %b want 8080/0", led_all, step); end
        cyc();
        checks++; if (led_all !== 16'h4040 || step !== 1'b1) begin fails++; $display("FAIL cp_resume_tick: led %h step %b want 4040/1", led_all, step); end
    endtask

    task automatic test_reset_in_switch();
        send_cmd(2'd1, 4'd5);
        cyc();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin fails++; $display("FAIL rs_in_switch: ready %b want 0", cmd_if.cmd_ready); end
        rst_n = 1'b0;
        cyc();
        checks++; if (led_all !== 16'h0101 || mode_o !== 2'd0) begin fails++; $display("FAIL rs_values: led %h mode %0d want 0101/0", led_all, mode_o); end
        checks++; if (cmd_if.cmd_ready !== 1'b1 || step !== 1'b0) begin fails++; $display("FAIL rs_ctrl: ready %b step %b want 1/0", cmd_if.cmd_ready, step); end
        rst_n = 1'b1;
        repeat (3) cyc();
        checks++; if (led_all !== 16'h0101 || step !== 1'b0) begin fails++; $display("FAIL rs_pre_tick: led %h step %b want 0101/0", led_all, step); end
        cyc();
        checks++; if (led_all !== 16'h0202 || step !== 1'b1) begin fails++; $display("FAIL rs_tick: led %h step %b want 0202/1", led_all, step); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_rotate_right();
        test_bounce();
        test_pause();
        test_blink();
        test_collision();
        test_cmd_with_pause();
        test_reset_in_switch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
